// File: rtl/rs_mem.sv
// rs_mem: memory-op reservation station feeding the memory functional unit.
//
// Loads and stores enter in program order, collect source-operand readiness
// from the CDB wakeup buses, and leave strictly in order from the head once
// their operands are ready and the memory FU can take them. A branch
// mispredict flushes the younger suffix of the queue.
//
// Handshake semantics (both directions): a transfer happens on a rising edge
// exactly when the producer's valid and the consumer's ready are both high in
// the cycle before that edge; valid never waits on ready. Dispatch side:
// dispatch_valid / dispatch_ready. Issue side: issued / fu_mem_ready, with
// issued already qualified by fu_mem_ready so the FU simply samples it.
// Neither side transfers in a mispredict cycle.
//
// Optional build macro: RS_MEM_WAKEUP_ISSUE_EN lets a same-cycle CDB match
// count toward head readiness (one cycle less wakeup-to-issue latency).
//
// Ports:
//   clk              clock, rising edge
//   reset            asynchronous active-low reset
//   dispatch_valid   dispatcher presents an op
//   dispatch_data    op fields (rs_data)
//   dispatch_ready   queue has a free slot this cycle
//   cdb_valid        per-bus broadcast valid
//   cdb_tag          per-bus physical register tag
//   mispredict       flush pulse
//   mispredict_tag   ROB tag of the mispredicted branch
//   curr_rob_tag     ROB tail (next tag to allocate)
//   fu_mem_ready     memory FU accepts an op
//   issued           head op leaves this cycle
//   data_out         head entry contents, zero when empty
//   count            occupied entries

package rs_mem_pkg;
    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [31:0] imm;
        logic [6:0]  pd;
        logic [6:0]  ps1;
        logic [6:0]  ps2;
        logic        ps1_ready;
        logic        ps2_ready;
        logic [4:0]  rob_index;
    } rs_data;

    localparam logic [6:0] OPC_LOAD = 7'b0000011;
endpackage

module rs_mem
    import rs_mem_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int NUM_CDB = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         dispatch_valid,
    input  rs_data                       dispatch_data,
    output logic                         dispatch_ready,
    input  logic [NUM_CDB-1:0]           cdb_valid,
    input  logic [NUM_CDB-1:0][6:0]      cdb_tag,
    input  logic                         mispredict,
    input  logic [4:0]                   mispredict_tag,
    input  logic [4:0]                   curr_rob_tag,
    input  logic                         fu_mem_ready,
    output logic                         issued,
    output rs_data                       data_out,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    rs_data           mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;

    logic [DEPTH-1:0] wake1;
    logic [DEPTH-1:0] wake2;
    logic [DEPTH-1:0] flush;
    logic [3:0]       rel [DEPTH];
    logic [3:0]       lim;
    logic [CW-1:0]    flush_cnt;
    logic             disp_w1;
    logic             disp_w2;
    rs_data           new_e;
    rs_data           head_e;
    logic             head_r1;
    logic             head_r2;
    logic             head_ok;
    logic             do_disp;

    // ROB tags are compared on their low 4 bits only.
    logic unused_tag_msb;
    assign unused_tag_msb = mispredict_tag[4] ^ curr_rob_tag[4];

    // Wakeup matches, flush selection and dispatch capture.
    always_comb begin
        wake1     = '0;
        wake2     = '0;
        flush     = '0;
        flush_cnt = '0;
        disp_w1   = 1'b0;
        disp_w2   = 1'b0;
        lim       = curr_rob_tag[3:0] - mispredict_tag[3:0];
        for (int i = 0; i < DEPTH; i++) begin
            // Age of the entry relative to the branch; only ops strictly
            // younger than the branch and older than the ROB tail go.
            rel[i]   = mem[i].rob_index[3:0] - mispredict_tag[3:0];
            flush[i] = valid[i] && (rel[i] != 4'd0) && (rel[i] < lim);
            flush_cnt = flush_cnt + CW'(flush[i]);
            for (int k = 0; k < NUM_CDB; k++) begin
                if (cdb_valid[k] && cdb_tag[k] == mem[i].ps1) wake1[i] = 1'b1;
                if (cdb_valid[k] && cdb_tag[k] == mem[i].ps2) wake2[i] = 1'b1;
            end
        end
        for (int k = 0; k < NUM_CDB; k++) begin
            if (cdb_valid[k] && cdb_tag[k] == dispatch_data.ps1) disp_w1 = 1'b1;
            if (cdb_valid[k] && cdb_tag[k] == dispatch_data.ps2) disp_w2 = 1'b1;
        end
        new_e           = dispatch_data;
        // x0 is hardwired, so a zero tag never waits.
        new_e.ps1_ready = dispatch_data.ps1_ready || disp_w1 || (dispatch_data.ps1 == 7'd0);
        new_e.ps2_ready = dispatch_data.ps2_ready || disp_w2 || (dispatch_data.ps2 == 7'd0);
    end

    assign head_e = mem[head];

`ifdef RS_MEM_WAKEUP_ISSUE_EN
    assign head_r1 = head_e.ps1_ready || wake1[head];
    assign head_r2 = head_e.ps2_ready || wake2[head];
`else
    assign head_r1 = head_e.ps1_ready;
    assign head_r2 = head_e.ps2_ready;
`endif

    // Loads need only the address base; everything else also needs ps2.
    assign head_ok        = head_r1 && ((head_e.opcode == OPC_LOAD) || head_r2);
    assign issued         = valid[head] && head_ok && fu_mem_ready && !mispredict;
    assign dispatch_ready = (count < CW'(DEPTH));
    assign do_disp        = dispatch_valid && dispatch_ready && !mispredict;
    assign data_out       = valid[head] ? head_e : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid[i] && wake1[i]) mem[i].ps1_ready <= 1'b1;
                if (valid[i] && wake2[i]) mem[i].ps2_ready <= 1'b1;
            end
            if (mispredict) begin
                // Flushed entries are a suffix, so the survivors stay
                // contiguous from head and tail lands right after them.
                valid <= valid & ~flush;
                count <= count - flush_cnt;
                tail  <= head + PW'(count - flush_cnt);
            end else begin
                if (issued) begin
                    valid[head] <= 1'b0;
                    head        <= head + PW'(1);
                end
                if (do_disp) begin
                    mem[tail]   <= new_e;
                    valid[tail] <= 1'b1;
                    tail        <= tail + PW'(1);
                end
                count <= count + CW'(do_disp) - CW'(issued);
            end
        end
    end

endmodule

// File: tb/tb_rs_mem.sv
// Testbench for rs_mem: directed scenarios followed by a random phase, all
// checked every cycle against a queue-based model of the reservation station.
module tb_rs_mem;
    import rs_mem_pkg::*;

    localparam int DEPTH   = 8;
    localparam int NUM_CDB = 2;
    localparam int CW      = $clog2(DEPTH) + 1;
    localparam int W       = $bits(rs_data);
    localparam logic [6:0] OPC_ST  = 7'b0100011;
    localparam logic [6:0] OPC_ALU = 7'b0110011;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic                    dispatch_valid;
    rs_data                  dispatch_data;
    logic                    dispatch_ready;
    logic [NUM_CDB-1:0]      cdb_valid;
    logic [NUM_CDB-1:0][6:0] cdb_tag;
    logic                    mispredict;
    logic [4:0]              mispredict_tag;
    logic [4:0]              curr_rob_tag;
    logic                    fu_mem_ready;
    logic                    issued;
    rs_data                  data_out;
    logic [CW-1:0]           count;

    rs_mem #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB)) dut (
        .clk            (clk),
        .reset          (reset),
        .dispatch_valid (dispatch_valid),
        .dispatch_data  (dispatch_data),
        .dispatch_ready (dispatch_ready),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .mispredict     (mispredict),
        .mispredict_tag (mispredict_tag),
        .curr_rob_tag   (curr_rob_tag),
        .fu_mem_ready   (fu_mem_ready),
        .issued         (issued),
        .data_out       (data_out),
        .count          (count)
    );

    // ---------------- scoreboard state ----------------
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [W-1:0] exp_q[$];
    logic [4:0] rob_tail;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic cdb_hit(input logic [6:0] t);
        logic h = 1'b0;
        for (int k = 0; k < NUM_CDB; k++)
            if (cdb_valid[k] && cdb_tag[k] == t) h = 1'b1;
        return h;
    endfunction

    // Whether the model's head op may leave this cycle (operands only).
    function automatic logic operands_ok(input rs_data e);
        logic r1 = e.ps1_ready;
        logic r2 = e.ps2_ready;
`ifdef RS_MEM_WAKEUP_ISSUE_EN
        r1 = r1 | cdb_hit(e.ps1);
        r2 = r2 | cdb_hit(e.ps2);
`endif
        return (e.opcode == 7'b0000011) ? r1 : (r1 && r2);
    endfunction

    function automatic rs_data mk_op(input logic [6:0] opc, input logic [6:0] p1, input logic r1,
                                     input logic [6:0] p2, input logic r2);
        rs_data o;
        o.opcode    = opc;
        o.func3     = 3'($urandom);
        o.imm       = $urandom;
        o.pd        = 7'($urandom_range(1, 63));
        o.ps1       = p1;
        o.ps2       = p2;
        o.ps1_ready = r1;
        o.ps2_ready = r2;
        o.rob_index = rob_tail;
        return o;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle();
        dispatch_valid = 1'b0;
        cdb_valid      = '0;
        mispredict     = 1'b0;
    endtask

    task automatic drive_op(input logic [6:0] opc, input logic [6:0] p1, input logic r1,
                            input logic [6:0] p2, input logic r2);
        dispatch_valid = 1'b1;
        dispatch_data  = mk_op(opc, p1, r1, p2, r2);
    endtask

    // One clock cycle: called at posedge+1 with inputs driven. Checks the
    // combinational outputs against the model, then advances the model.
    task automatic step(input string tag);
        logic [W-1:0] head_exp;
        logic         exp_iss;
        logic         acc;
        rs_data       e;
        rs_data       nd;
        logic [3:0]   lim;
        logic [3:0]   d;
        curr_rob_tag = rob_tail;
        #2;
        exp_iss  = 1'b0;
        head_exp = '0;
        if (exp_q.size() > 0) begin
            e        = rs_data'(exp_q[0]);
            head_exp = exp_q[0];
            exp_iss  = operands_ok(e) && fu_mem_ready && !mispredict;
        end
        check({tag, ":count"}, W'(count), W'(exp_q.size()));
        check({tag, ":dispatch_ready"}, W'(dispatch_ready), W'(exp_q.size() < DEPTH));
        check({tag, ":issued"}, W'(issued), W'(exp_iss));
        check({tag, ":data_out"}, W'(data_out), head_exp);
        acc = dispatch_valid && (exp_q.size() < DEPTH) && !mispredict;
        nd  = dispatch_data;
        nd.ps1_ready = nd.ps1_ready | cdb_hit(nd.ps1) | (nd.ps1 == 7'd0);
        nd.ps2_ready = nd.ps2_ready | cdb_hit(nd.ps2) | (nd.ps2 == 7'd0);
        @(posedge clk);
        if (mispredict) begin
            lim = curr_rob_tag[3:0] - mispredict_tag[3:0];
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                e = rs_data'(exp_q[i]);
                d = e.rob_index[3:0] - mispredict_tag[3:0];
                if (d != 4'd0 && d < lim) exp_q.delete(i);
            end
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            e = rs_data'(exp_q[i]);
            if (cdb_hit(e.ps1)) e.ps1_ready = 1'b1;
            if (cdb_hit(e.ps2)) e.ps2_ready = 1'b1;
            exp_q[i] = e;
        end
        if (!mispredict) begin
            if (exp_iss) void'(exp_q.pop_front());
            if (acc) begin
                exp_q.push_back(nd);
                rob_tail = rob_tail + 5'd1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        exp_q.delete();
        rob_tail = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rs_data e;
        int     k;
        logic [4:0] mtag;

        reset          = 1'b0;
        rob_tail       = '0;
        dispatch_data  = '0;
        cdb_tag        = '0;
        mispredict_tag = '0;
        curr_rob_tag   = '0;
        fu_mem_ready   = 1'b0;
        idle();
        @(posedge clk);
        #1;
        step("in_reset");
        reset = 1'b1;
        step("after_reset");

        // Reset asserted mid-stream with three entries held.
        for (int i = 0; i < 3; i++) begin
            drive_op(7'b0000011, 7'd9, 1'b1, 7'd0, 1'b0);
            step("fill3");
        end
        idle();
        step("held3");
        reset = 1'b0;
        #2;
        check("mid_reset:count", W'(count), W'(0));
        check("mid_reset:issued", W'(issued), W'(0));
        check("mid_reset:data_out", W'(data_out), W'(0));
        check("mid_reset:dispatch_ready", W'(dispatch_ready), W'(1));
        exp_q.delete();
        rob_tail = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive_op(7'b0000011, 7'd9, 1'b1, 7'd0, 1'b0);
        step("first_after_reset");
        idle();
        step("first_visible");
        fu_mem_ready = 1'b1;
        step("drain_one");
        step("empty");

        // Eight ready loads with the FU stalled, a ninth rejected.
        fu_mem_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive_op(7'b0000011, 7'($urandom_range(1, 15)), 1'b1, 7'd0, 1'b0);
            step("fill8");
        end
        idle();
        step("full");
        check("full:count", W'(count), W'(DEPTH));
        // Full queue with issue and dispatch offered together.
        fu_mem_ready = 1'b1;
        drive_op(7'b0000011, 7'd3, 1'b1, 7'd0, 1'b0);
        step("full_issue_disp");
        idle();
        check("full_issue_disp:count", W'(count), W'(DEPTH - 1));
        for (int i = 0; i < 8; i++) step("drain_wrap");

        // Store blocked on ps2=12 holds back a ready load.
        fu_mem_ready = 1'b0;
        drive_op(OPC_ST, 7'd3, 1'b1, 7'd12, 1'b0);
        step("st_blocked");
        drive_op(7'b0000011, 7'd4, 1'b1, 7'd0, 1'b0);
        step("ld_behind");
        idle();
        fu_mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) step("wait_12");
        cdb_valid  = 2'b10;
        cdb_tag[1] = 7'd12;
        step("bcast_12");
        idle();
        for (int i = 0; i < 3; i++) step("after_12");

        // Operand broadcast in the dispatch cycle is captured.
        drive_op(7'b0000011, 7'd5, 1'b0, 7'd0, 1'b0);
        cdb_valid  = 2'b01;
        cdb_tag[0] = 7'd5;
        step("disp_bcast_5");
        idle();
        step("issue_5");
        step("empty_5");

        // Selective flush: rob 3..6, branch 4, tail 7.
        do_reset();
        rob_tail     = 5'd3;
        fu_mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_op(7'b0000011, 7'd20, 1'b0, 7'd0, 1'b0);
            step("flush_fill");
        end
        idle();
        fu_mem_ready   = 1'b1;
        mispredict     = 1'b1;
        mispredict_tag = 5'd4;
        step("flush_cycle");
        idle();
        rob_tail = 5'd5;
        check("flush:count", W'(count), W'(2));
        step("after_flush");

        // Wrapping flush: rob 15,0,1, branch 14, tail 2.
        do_reset();
        rob_tail     = 5'd15;
        fu_mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_op(OPC_ALU, 7'd21, 1'b0, 7'd22, 1'b0);
            step("wrap_fill");
        end
        idle();
        mispredict     = 1'b1;
        mispredict_tag = 5'd14;
        step("wrap_flush");
        idle();
        rob_tail = 5'd15;
        check("wrap_flush:count", W'(count), W'(0));
        step("after_wrap_flush");

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            idle();
            fu_mem_ready = ($urandom_range(0, 99) < 65);
            for (int b = 0; b < NUM_CDB; b++) begin
                cdb_valid[b] = ($urandom_range(0, 99) < 40);
                cdb_tag[b]   = 7'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 99) < 60) begin
                k = $urandom_range(0, 2);
                drive_op((k == 0) ? 7'b0000011 : (k == 1) ? OPC_ST : OPC_ALU,
                         7'($urandom_range(0, 15)), ($urandom_range(0, 99) < 30),
                         7'($urandom_range(0, 15)), ($urandom_range(0, 99) < 30));
            end
            if (exp_q.size() > 0 && $urandom_range(0, 99) < 6) begin
                k = $urandom_range(0, exp_q.size());
                if (k == exp_q.size()) begin
                    e    = rs_data'(exp_q[0]);
                    mtag = e.rob_index - 5'd1;
                end else begin
                    e    = rs_data'(exp_q[k]);
                    mtag = e.rob_index;
                end
                mispredict     = 1'b1;
                mispredict_tag = mtag;
                step("rand_flush");
                rob_tail = mtag + 5'd1;
            end else begin
                step("rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rs_mem.md
# rs_mem

Memory-op reservation station directly upstream of the memory functional unit. Accepts dispatched loads/stores in program order, tracks source-operand readiness via CDB wakeup, and issues the oldest op in order when its operands are ready and the memory FU signals ready. Selectively flushes ops younger than a mispredicted branch.

## Interface
- DEPTH, 8: entry count; power of two, 2–16.
- NUM_CDB, 2: number of wakeup broadcast buses.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- dispatch_valid  in  1  dispatcher presents an op.
- dispatch_data  in  rs_data  op fields: Opcode, func3, imm, pd, ps1, ps2, ps1_ready, ps2_ready, rob_index.
- dispatch_ready  out  1  queue can accept an op this cycle.
- cdb_valid  in  NUM_CDB  broadcast valid, per bus.
- cdb_tag  in  NUM_CDB×7  physical register tag produced, per bus.
- mispredict  in  1  branch mispredict flush pulse.
- mispredict_tag  in  5  ROB tag of the mispredicted branch.
- curr_rob_tag  in  5  ROB tail (next tag to allocate).
- fu_mem_ready  in  1  memory FU can accept an op.
- issued  out  1  head op issued this cycle.
- data_out  out  rs_data  head entry contents; PRF read tags are data_out.ps1 and data_out.ps2.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Circular FIFO: head/tail pointers wrap at DEPTH-1 → 0. Occupancy counter is 0..DEPTH.
- Dispatch: when dispatch_valid && dispatch_ready && !mispredict, write the entry at tail, then increment tail.
  - Source ready bits are the OR of dispatch_data.psX_ready and any same-cycle cdb_valid[k] && cdb_tag[k]==psX.
  - Tag 0 (x0) is always ready.
- dispatch_ready = (count < DEPTH). No same-cycle dispatch-on-issue when full.
- Wakeup: every valid entry sets psX_ready when any cdb_valid[k] && cdb_tag[k]==psX. Ready bits are never cleared.
- Operand requirement:
  - Load (Opcode 7'b0000011) needs ps1 ready.
  - Store (7'b0100011) needs ps1 and ps2 ready.
  - Any other opcode is treated as store-like.
- data_out always reflects the head entry, or all-zero when empty. It does not depend on fu_mem_ready, so there is no combinational loop through the FU.
- issued = head valid && head operands ready && fu_mem_ready && !mispredict. On issue, head is popped at the clock edge.
- Strictly in-order issue. A non-ready head blocks all younger ops.
- Mispredict:
  - An entry is flushed iff ((rob_index − mispredict_tag) mod 16) is in [1, ((curr_rob_tag − mispredict_tag) mod 16) − 1], computed on the low 4 bits.
  - Flushed entries form a suffix of the FIFO, so tail is rewound to the oldest flushed slot and count is reduced accordingly.
  - No dispatch and no issue occur in the mispredict cycle.
- Simultaneous dispatch and issue (not full, no mispredict): count is unchanged; head and tail both advance.
- Reset (asserted at any time): head=tail=0, count=0, all valid bits 0, issued=0, data_out=0, dispatch_ready=1. State is held until reset deasserts.

## Timing
- Dispatch to earliest issue: 1 cycle. An op written at edge N can issue in cycle N+1.
- Wakeup to issue: ready bit registered at edge N; issue possible in cycle N+1. With the macro below, issue is possible in cycle N.
- issued is combinational and valid in the same cycle as data_out. The memory FU samples both at the next edge.
- Flush takes effect at the edge ending the mispredict cycle. dispatch_ready reflects the new count in the following cycle.

## Configuration
- RS_MEM_WAKEUP_ISSUE_EN defined: head readiness includes the current-cycle CDB match, so an op whose last operand is broadcast this cycle issues in the same cycle.
- Not defined: issue uses registered ready bits only, giving one extra cycle of wakeup-to-issue latency. Functional results are identical.

## Test plan
- Reset low mid-stream with 3 entries held → same cycle: count=0, issued=0, data_out=0, dispatch_ready=1. After release, first dispatch lands in slot 0.
- Dispatch 8 loads with ps1_ready=1 and fu_mem_ready=0 → count=8, dispatch_ready=0. A 9th dispatch is ignored. Raise fu_mem_ready → rob_index order 0..7 issued one per cycle, with head wrapping 7→0.
- Store with ps1 ready, ps2=7'd12 not ready at head; a younger ready load behind it → no issue until cdb_tag=12 valid. Store issues first (cycle N+1, or cycle N with the macro), then the load.
- Dispatch op with ps1=7'd5 while cdb broadcasts 5 in the same cycle → entry captured ready; issues next cycle.
- Entries with rob_index 3,4,5,6, mispredict_tag=4, curr_rob_tag=7 → entries 5 and 6 flushed, count=2, no issue that cycle. Repeat with tags wrapping (mispredict_tag=14, entries 15,0,1, curr_rob_tag=2) → entries 15, 0, 1 flushed.
- Full queue plus simultaneous issue and dispatch → dispatch rejected (dispatch_ready=0); count goes 8→7.
